mult4u_redund_ctrl: RTL and testbench
=====================================

// Module: mult4u_redund_ctrl
// PURPOSE
// - Time-redundancy controller for the combinational 4-bit unsigned multiplier core (O = A*B, 8-bit).
// - Accepts one operand pair per transaction and runs the core twice, first A*B and then B*A (commutative swap).
// - On mismatch it runs a third A*B pass and takes a majority vote; if no majority, it retries up to MAX_RETRY rounds.
// - Sits between the requester and the core; reports corrected and uncorrectable fault events.
// PARAMETERS
// - SETTLE_CYC  1  clock cycles each pass holds operands before core_p is sampled (>=1)
// - MAX_RETRY   2  extra full rounds allowed after a failed vote (0..7)
// - CNT_W       8  width of saturating fault/error counters
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      operand pair valid
// - in_ready   out  1      controller can accept (IDLE only)
// - in_a       in   4      operand A
// - in_b       in   4      operand B
// - out_valid  out  1      result valid
// - out_ready  in   1      consumer accepts result
// - out_p      out  8      product
// - out_corr   out  1      result produced by vote after mismatch
// - out_err    out  1      no agreement after all rounds
// - core_a     out  4      core operand A (registered)
// - core_b     out  4      core operand B (registered)
// - core_p     in   8      core product
// - fault_cnt  out  CNT_W  saturating count of mismatch events (P1!=P2)
// - err_cnt    out  CNT_W  saturating count of out_err transactions
// - cnt_clr    in   1      synchronous clear of both counters
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 except in_ready=1; r1/r2/round/counters=0. Reset mid-transaction abandons it with no response.
// - States: IDLE, P1, P2, P3, RESP.
// - IDLE: in_ready=1, core_a/b=0. On in_valid: latch A,B; core_a=A, core_b=B; round=0 -> P1.
// - P1: hold SETTLE_CYC cycles; on last cycle r1<=core_p, core_a=B, core_b=A -> P2.
// - P2: hold SETTLE_CYC; on last cycle compare core_p vs r1:
//   - equal: out_p=r1, corr=0, err=0 -> RESP.
//   - unequal: r2<=core_p, fault_cnt++, core_a=A, core_b=B -> P3.
// - P3: hold SETTLE_CYC; on last cycle r3=core_p:
//   - r3==r1 or r3==r2: out_p=r3, corr=1 -> RESP.
//   - neither matches and round<MAX_RETRY: round++, operands A,B -> P1.
//   - neither matches and round==MAX_RETRY: out_p=r1, err=1, err_cnt++ -> RESP.
// - RESP: out_valid=1; out_p/corr/err stable until out_ready. Handshake -> IDLE, core_a/b=0, out_valid=0. in_ready=0.
// - Latency, no fault: out_valid asserts 2*SETTLE_CYC+1 edges after the accepting edge; +SETTLE_CYC per P3, +2*SETTLE_CYC per retry round.
// - Minimum issue interval: 2*SETTLE_CYC+2 cycles (RESP handshake, then IDLE accept).
// - Counters saturate at 2^CNT_W-1. cnt_clr wins over a simultaneous increment.
// - in_ready is a function of state only; no combinational path from out_ready or in_valid to in_ready.
// - Edge operands need no special case: 0*x=0, 15*15=0xE1.
// STRUCTURE
// - Shared package mult4u_pkg: state enum (IDLE,P1,P2,P3,RESP), OP_W=4, PROD_W=8.
// - One sub-module: mult4u_sat_cnt (CNT_W, inc, clr, saturating), used twice.
// - Core netlist is instantiated outside this block; connected via core_a/b/p.
// TESTING (bench core model: behavioural product with per-pass injectable output corruption; SETTLE_CYC=1)
// - A=0xF, B=0xF, no fault -> out_p=0xE1, corr=0, err=0, out_valid 3 edges after accept.
// - A=3, B=5, flip bit0 in P2 only -> P1=0x0F, P2=0x0E, P3=0x0F; out_p=0x0F, corr=1, fault_cnt=1.
// - Core returns 1,2,3 every round, MAX_RETRY=2 -> 3 rounds (9 passes); out_err=1, out_p=0x01, err_cnt=1, fault_cnt=3.
// - Hold out_ready=0 for 5 cycles in RESP with in_valid=1 -> out_* stable, in_ready=0, no second accept.
// - Assert rst during P2 -> outputs 0, in_ready=1; next op A=0, B=9 -> out_p=0x00, corr=0.
// - CNT_W=2, 5 P2 mismatches -> fault_cnt=3; cnt_clr on the same edge as a mismatch -> fault_cnt=0.

Source files
------------

// File: rtl/mult4u_pkg.sv
// Shared types and widths for the 4x4 unsigned multiplier redundancy controller.
package mult4u_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    RESP = 3'd4
  } state_e;

endpackage

// File: rtl/mult4u_sat_cnt.sv
// Saturating event counter; a clear on the same edge as an increment wins.
module mult4u_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mult4u_redund_ctrl.sv
// Time-redundant wrapper around an external 4x4 multiplier core: A*B, then B*A,
// a third A*B pass with majority vote on mismatch, and bounded retry rounds.
module mult4u_redund_ctrl
  import mult4u_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              out_corr,
  output logic              out_err,
  output logic [OP_W-1:0]   core_a,
  output logic [OP_W-1:0]   core_b,
  input  logic [PROD_W-1:0] core_p,
  output logic [CNT_W-1:0]  fault_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic [PROD_W-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [PROD_W-1:0] out_p_q, out_p_d;
  logic              out_corr_q, out_corr_d, out_err_q, out_err_d;
  logic [2:0]        round_q, round_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              last_cyc, fault_inc, err_inc;

  assign last_cyc = (settle_q == SW'(SETTLE_CYC - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    out_p_d    = out_p_q;
    out_corr_d = out_corr_q;
    out_err_d  = out_err_q;
    round_d    = round_q;
    settle_d   = settle_q;
    fault_inc  = 1'b0;
    err_inc    = 1'b0;

    // Pass states share one settle counter that wraps on the sampling cycle.
    if (state_q == P1 || state_q == P2 || state_q == P3)
      settle_d = last_cyc ? '0 : settle_q + SW'(1);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          core_a_d = in_a;
          core_b_d = in_b;
          round_d  = '0;
          settle_d = '0;
          state_d  = P1;
        end
      end
      P1: begin
        if (last_cyc) begin
          r1_d     = core_p;
          core_a_d = b_q;
          core_b_d = a_q;
          state_d  = P2;
        end
      end
      P2: begin
        if (last_cyc) begin
          if (core_p == r1_q) begin
            out_p_d    = r1_q;
            out_corr_d = 1'b0;
            out_err_d  = 1'b0;
            state_d    = RESP;
          end else begin
            r2_d      = core_p;
            fault_inc = 1'b1;
            core_a_d  = a_q;
            core_b_d  = b_q;
            state_d   = P3;
          end
        end
      end
      P3: begin
        if (last_cyc) begin
          if (core_p == r1_q || core_p == r2_q) begin
            out_p_d    = core_p;
            out_corr_d = 1'b1;
            out_err_d  = 1'b0;
            state_d    = RESP;
          end else if (round_q < 3'(MAX_RETRY)) begin
            round_d  = round_q + 3'd1;
            core_a_d = a_q;
            core_b_d = b_q;
            state_d  = P1;
          end else begin
            out_p_d    = r1_q;
            out_corr_d = 1'b0;
            out_err_d  = 1'b1;
            err_inc    = 1'b1;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        if (out_ready) begin
          core_a_d   = '0;
          core_b_d   = '0;
          out_p_d    = '0;
          out_corr_d = 1'b0;
          out_err_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      core_a_q   <= '0;
      core_b_q   <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      out_p_q    <= '0;
      out_corr_q <= 1'b0;
      out_err_q  <= 1'b0;
      round_q    <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      out_p_q    <= out_p_d;
      out_corr_q <= out_corr_d;
      out_err_q  <= out_err_d;
      round_q    <= round_d;
      settle_q   <= settle_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign out_p     = out_p_q;
  assign out_corr  = out_corr_q;
  assign out_err   = out_err_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;

  mult4u_sat_cnt #(.CNT_W(CNT_W)) u_fault_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fault_inc),
    .clr (cnt_clr),
    .cnt (fault_cnt)
  );

  mult4u_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (cnt_clr),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_mult4u_redund_ctrl.sv
// Self-checking bench: behavioural multiplier core with per-pass output corruption.
module tb_mult4u_redund_ctrl;

  localparam int MAX_RETRY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, out_corr, out_err, cnt_clr;
  logic [3:0] in_a, in_b, core_a, core_b;
  logic [7:0] out_p, core_p, fault_cnt, err_cnt;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_corr2, out_err2, cnt_clr2;
  logic [3:0] in_a2, in_b2, core_a2, core_b2;
  logic [7:0] out_p2, core_p2;
  logic [1:0] fault_cnt2, err_cnt2;

  int checks = 0;
  int errors = 0;

  logic [7:0] mask [16];
  bit         core_fixed;
  bit         flip2;
  int         pass, pass2;
  int         m_fault, m_err;

  function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
    return {4'b0, a} * {4'b0, b};
  endfunction

  // Pass index = edges since acceptance while the controller is busy.
  always @(posedge clk) begin
    if (in_ready && in_valid) pass <= 0;
    else if (!in_ready && !out_valid) pass <= pass + 1;
    if (in_ready2 && in_valid2) pass2 <= 0;
    else if (!in_ready2 && !out_valid2) pass2 <= pass2 + 1;
  end

  assign core_p  = core_fixed ? 8'(pass % 3 + 1)
                              : (mul(core_a, core_b) ^ ((pass < 16) ? mask[pass[3:0]] : 8'h00));
  assign core_p2 = mul(core_a2, core_b2) ^ ((flip2 && pass2 == 1) ? 8'h01 : 8'h00);

  mult4u_redund_ctrl #(.SETTLE_CYC(1), .MAX_RETRY(MAX_RETRY), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_corr(out_corr),
    .out_err(out_err), .core_a(core_a), .core_b(core_b), .core_p(core_p),
    .fault_cnt(fault_cnt), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );

  mult4u_redund_ctrl #(.SETTLE_CYC(1), .MAX_RETRY(MAX_RETRY), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_p(out_p2), .out_corr(out_corr2),
    .out_err(out_err2), .core_a(core_a2), .core_b(core_b2), .core_p(core_p2),
    .fault_cnt(fault_cnt2), .err_cnt(err_cnt2), .cnt_clr(cnt_clr2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // lat counts edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic txn(input logic [3:0] a, input logic [3:0] b,
                     output logic [7:0] p, output logic c, output logic e, output int lat);
    int w;
    w = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("resp_timeout", 0, 1);
    p = out_p; c = out_corr; e = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reference: voting rules applied with plain arithmetic over the pass sequence.
  task automatic model(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] p, output logic c, output logic e, output int faults);
    logic [7:0] p1, p2, p3;
    int k;
    k = 0; faults = 0; c = 1'b0; e = 1'b0; p = '0;
    for (int r = 0; r <= MAX_RETRY; r++) begin
      p1 = mul(a, b) ^ mask[k];
      p2 = mul(b, a) ^ mask[k+1];
      if (p1 == p2) begin p = p1; return; end
      faults++;
      p3 = mul(a, b) ^ mask[k+2];
      if (p3 == p1 || p3 == p2) begin p = p3; c = 1'b1; return; end
      k += 3;
      p = p1;
    end
    e = 1'b1;
  endtask

  task automatic txn2(input bit clr);
    int w;
    w = 0;
    in_a2 = 4'd3; in_b2 = 4'd5; flip2 = 1'b1; in_valid2 = 1'b1;
    while (!in_ready2 && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    cnt_clr2 = clr;
    @(posedge clk); #1;
    cnt_clr2 = 1'b0;
    w = 0;
    while (!out_valid2 && w < 50) begin @(posedge clk); #1; w++; end
    if (!out_valid2) chk("resp2_timeout", 0, 1);
    chk("dut2_out_p", out_p2, 8'h0F);
    chk("dut2_corr", out_corr2, 1);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [7:0] m0, m1, m2;
    logic [7:0] p;
    logic       corr, err;
    int         faults, lat;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] gp, ep;
  logic       gc, ge, ec, ee;
  int         glat, ef;

  initial begin
    tbl[0] = '{4'hF, 4'hF, 8'h00, 8'h00, 8'h00, 8'hE1, 1'b0, 1'b0, 0, 3};
    tbl[1] = '{4'h3, 4'h5, 8'h00, 8'h01, 8'h00, 8'h0F, 1'b1, 1'b0, 1, 4};
    tbl[2] = '{4'h0, 4'h9, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 3};
    tbl[3] = '{4'h2, 4'h3, 8'h00, 8'h08, 8'h08, 8'h0E, 1'b1, 1'b0, 1, 4};
    tbl[4] = '{4'h7, 4'h8, 8'h10, 8'h00, 8'h00, 8'h38, 1'b1, 1'b0, 1, 4};
    tbl[5] = '{4'h1, 4'hF, 8'h00, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0, 0, 3};

    rst = 1'b1; in_valid = 0; out_ready = 0; cnt_clr = 0; in_a = 0; in_b = 0;
    in_valid2 = 0; out_ready2 = 0; cnt_clr2 = 0; in_a2 = 0; in_b2 = 0; flip2 = 0;
    core_fixed = 0; m_fault = 0; m_err = 0;
    for (int i = 0; i < 16; i++) mask[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_flags", {out_corr, out_err}, 0);
    chk("rst_core_ab", {core_a, core_b}, 0);
    chk("rst_cnts", {fault_cnt, err_cnt}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      mask[0] = tbl[i].m0; mask[1] = tbl[i].m1; mask[2] = tbl[i].m2;
      txn(tbl[i].a, tbl[i].b, gp, gc, ge, glat);
      m_fault += tbl[i].faults;
      chk($sformatf("tbl%0d_p", i), gp, tbl[i].p);
      chk($sformatf("tbl%0d_corr", i), gc, tbl[i].corr);
      chk($sformatf("tbl%0d_err", i), ge, tbl[i].err);
      chk($sformatf("tbl%0d_lat", i), glat, tbl[i].lat);
      chk($sformatf("tbl%0d_fault_cnt", i), fault_cnt, m_fault);
    end
    for (int i = 0; i < 16; i++) mask[i] = 8'h00;

    // Core stuck returning 1,2,3 each round: all retries exhausted.
    core_fixed = 1'b1;
    txn(4'h5, 4'h6, gp, gc, ge, glat);
    core_fixed = 1'b0;
    m_fault += 3; m_err += 1;
    chk("fix_p", gp, 8'h01);
    chk("fix_err", ge, 1);
    chk("fix_corr", gc, 0);
    chk("fix_lat", glat, 10);
    chk("fix_fault_cnt", fault_cnt, m_fault);
    chk("fix_err_cnt", err_cnt, m_err);

    // Back-pressure in RESP with a pending request.
    in_a = 4'h4; in_b = 4'h4; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 20 && !out_valid; w++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_p", out_p, 8'h10);
      chk("hold_flags", {out_corr, out_err}, 0);
      chk("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_ready", in_ready, 1);

    // Asynchronous reset during P2.
    mask[1] = 8'h01;
    in_a = 4'h6; in_b = 4'h7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_core_ab", {core_a, core_b}, 0);
    chk("midrst_cnts", {fault_cnt, err_cnt}, 0);
    m_fault = 0; m_err = 0; mask[1] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(4'h0, 4'h9, gp, gc, ge, glat);
    chk("postrst_p", gp, 8'h00);
    chk("postrst_corr", gc, 0);

    // Randomised transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++)
        mask[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'h00;
      model(ra, rb, ep, ec, ee, ef);
      txn(ra, rb, gp, gc, ge, glat);
      m_fault = (m_fault + ef > 255) ? 255 : m_fault + ef;
      m_err   = (m_err + int'(ee) > 255) ? 255 : m_err + int'(ee);
      chk("rnd_p", gp, ep);
      chk("rnd_corr", gc, ec);
      chk("rnd_err", ge, ee);
      chk("rnd_fault_cnt", fault_cnt, m_fault);
      chk("rnd_err_cnt", err_cnt, m_err);
    end

    // Narrow counters: saturation, then clear racing an increment.
    for (int i = 1; i <= 5; i++) begin
      txn2(1'b0);
      chk($sformatf("sat_fault_cnt%0d", i), fault_cnt2, (i > 3) ? 3 : i);
    end
    txn2(1'b1);
    chk("clr_wins", fault_cnt2, 0);
    chk("dut2_err_cnt", err_cnt2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
